// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: pixel position counters, sync levels and the
// data-island FSM that interleaves packets into horizontal blanking.
module hdmi_period_scheduler #(
  parameter int FRAME_WIDTH   = 800,
  parameter int FRAME_HEIGHT  = 525,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ISLAND_START  = 644,
  parameter int MAX_PACKETS   = 2
) (
  input  logic       CLK_PIXEL,
  input  logic       RESET,
  input  logic       packet_pending,
  output logic       packet_ack,
  output logic [2:0] mode,
  output logic [4:0] packet_cycle,
  output logic [9:0] cx,
  output logic [9:0] cy,
  output logic       hsync,
  output logic       vsync
);

  // states: IDLE control | PRE island preamble | LEAD/TRAIL guard bands | DATA packet payload
  // low three bits of each code are the mode shown while no video period applies
  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_PRE   = 4'b0100;
  localparam logic [3:0] S_LEAD  = 4'b0101;
  localparam logic [3:0] S_DATA  = 4'b0110;
  localparam logic [3:0] S_TRAIL = 4'b1101;

  localparam int CW = $clog2(MAX_PACKETS + 1);

  localparam logic [9:0] CX_LAST   = 10'(FRAME_WIDTH - 1);
  localparam logic [9:0] CY_LAST   = 10'(FRAME_HEIGHT - 1);
  localparam logic [9:0] CX_SAMPLE = 10'(ISLAND_START - 1);
  localparam logic [9:0] SCR_W     = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SCR_H     = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] CY_PRE    = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] VPRE_LO   = 10'(FRAME_WIDTH - 10);
  localparam logic [9:0] VPRE_HI   = 10'(FRAME_WIDTH - 3);
  localparam logic [9:0] VGB_LO    = 10'(FRAME_WIDTH - 2);
  localparam logic [9:0] HS_LO     = 10'd656;
  localparam logic [9:0] HS_HI     = 10'd751;
  localparam logic [9:0] VS_LO     = 10'd490;
  localparam logic [9:0] VS_HI     = 10'd491;
  localparam logic [CW-1:0] PKT_MAX = CW'(MAX_PACKETS);

  logic [9:0]    r_cx;
  logic [9:0]    r_cy;
  logic [3:0]    r_state;
  logic [2:0]    r_tmr;
  logic [4:0]    r_pkt_cycle;
  logic [CW-1:0] r_pkt_cnt;
  logic          r_ack;
  logic [2:0]    r_mode;
  logic          r_hsync;
  logic          r_vsync;

  logic [9:0]    w_cx_nxt;
  logic [9:0]    w_cy_nxt;
  logic [3:0]    w_state_nxt;
  logic [2:0]    w_tmr_nxt;
  logic [4:0]    w_pc_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ack_nxt;
  logic [2:0]    w_mode_nxt;
  logic          w_vid_act;
  logic          w_pre_line;

  assign cx           = r_cx;
  assign cy           = r_cy;
  assign mode         = r_mode;
  assign packet_ack   = r_ack;
  assign packet_cycle = r_pkt_cycle;
  assign hsync        = r_hsync;
  assign vsync        = r_vsync;

  always_comb begin
    w_cx_nxt = r_cx + 10'd1;
    w_cy_nxt = r_cy;
    if (r_cx == CX_LAST) begin
      w_cx_nxt = '0;
      w_cy_nxt = (r_cy == CY_LAST) ? '0 : r_cy + 10'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pc_nxt    = r_pkt_cycle;
    w_cnt_nxt   = r_pkt_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_pc_nxt  = '0;
        if (r_cx == CX_SAMPLE && packet_pending) begin
          w_state_nxt = S_PRE;
          w_tmr_nxt   = 3'd7;
        end
      end
      S_PRE: begin
        if (r_tmr == 3'd0) begin
          w_state_nxt = S_LEAD;
          w_tmr_nxt   = 3'd1;
        end else begin
          w_tmr_nxt = r_tmr - 3'd1;
        end
      end
      S_LEAD: begin
        if (r_tmr == 3'd0) begin
          w_state_nxt = S_DATA;
          w_pc_nxt    = '0;
          w_cnt_nxt   = r_pkt_cnt + CW'(1);
        end else begin
          w_tmr_nxt = r_tmr - 3'd1;
        end
      end
      S_DATA: begin
        if (r_pkt_cycle == 5'd31) begin
          w_pc_nxt = '0;
          if (packet_pending && r_pkt_cnt < PKT_MAX) begin
            w_cnt_nxt = r_pkt_cnt + CW'(1);
          end else begin
            w_state_nxt = S_TRAIL;
            w_tmr_nxt   = 3'd1;
          end
        end else begin
          w_pc_nxt = r_pkt_cycle + 5'd1;
        end
      end
      S_TRAIL: begin
        if (r_tmr == 3'd0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_tmr_nxt = r_tmr - 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = '0;
        w_pc_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // outputs are computed for the next position so they line up with cx/cy
  always_comb begin
    w_vid_act  = (w_cx_nxt < SCR_W) && (w_cy_nxt < SCR_H);
    w_pre_line = (w_cy_nxt < CY_PRE) || (w_cy_nxt == CY_LAST);
    w_ack_nxt  = (w_state_nxt == S_DATA) && (w_pc_nxt == 5'd0);
    if (w_vid_act) begin
      w_mode_nxt = 3'd3;
    end else if (w_pre_line && w_cx_nxt >= VPRE_LO && w_cx_nxt <= VPRE_HI) begin
      w_mode_nxt = 3'd1;
    end else if (w_pre_line && w_cx_nxt >= VGB_LO) begin
      w_mode_nxt = 3'd2;
    end else begin
      w_mode_nxt = w_state_nxt[2:0];
    end
  end

  always_ff @(posedge CLK_PIXEL) begin
    if (RESET) begin
      r_cx        <= '0;
      r_cy        <= '0;
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_pkt_cycle <= '0;
      r_pkt_cnt   <= '0;
      r_ack       <= 1'b0;
      r_mode      <= 3'd3;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
    end else begin
      r_cx        <= w_cx_nxt;
      r_cy        <= w_cy_nxt;
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_pkt_cycle <= w_pc_nxt;
      r_pkt_cnt   <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_mode      <= w_mode_nxt;
      r_hsync     <= (w_cx_nxt >= HS_LO) && (w_cx_nxt <= HS_HI);
      r_vsync     <= (w_cy_nxt >= VS_LO) && (w_cy_nxt <= VS_HI);
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench: default-size instance for per-line timing, and a narrow
// instance (full 525-line height) for frame wrap and vsync.
module tb_hdmi_period_scheduler;

  logic       clk;
  logic       rst_d, pend_d, ack_d, hs_d, vs_d;
  logic [2:0] mode_d;
  logic [4:0] pc_d;
  logic [9:0] cx_d, cy_d;
  logic       rst_f, pend_f, ack_f, hs_f, vs_f;
  logic [2:0] mode_f;
  logic [4:0] pc_f;
  logic [9:0] cx_f, cy_f;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hdmi_period_scheduler u_dut (
    .CLK_PIXEL(clk), .RESET(rst_d), .packet_pending(pend_d), .packet_ack(ack_d),
    .mode(mode_d), .packet_cycle(pc_d), .cx(cx_d), .cy(cy_d), .hsync(hs_d), .vsync(vs_d)
  );

  hdmi_period_scheduler #(
    .FRAME_WIDTH(78), .FRAME_HEIGHT(525), .SCREEN_WIDTH(16), .SCREEN_HEIGHT(480),
    .ISLAND_START(20), .MAX_PACKETS(1)
  ) u_frm (
    .CLK_PIXEL(clk), .RESET(rst_f), .packet_pending(pend_f), .packet_ack(ack_f),
    .mode(mode_f), .packet_cycle(pc_f), .cx(cx_f), .cy(cy_f), .hsync(hs_f), .vsync(vs_f)
  );

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // npk = packets expected in this line's island (0 = no island)
  function automatic int exp_mode(int x, int y, int npk, int fw, int fh, int sw, int sh, int isl);
    int rel;
    if (x < sw && y < sh) return 3;
    if ((y < sh - 1 || y == fh - 1) && x >= fw - 10 && x <= fw - 3) return 1;
    if ((y < sh - 1 || y == fh - 1) && x >= fw - 2) return 2;
    if (npk == 0) return 0;
    rel = x - isl;
    if (rel >= 0 && rel < 8) return 4;
    if (rel >= 8 && rel < 10) return 5;
    if (rel >= 10 && rel < 10 + 32 * npk) return 6;
    if (rel >= 10 + 32 * npk && rel < 12 + 32 * npk) return 5;
    return 0;
  endfunction

  function automatic int exp_pc(int x, int npk, int isl);
    int rel;
    rel = x - isl;
    if (npk > 0 && rel >= 10 && rel < 10 + 32 * npk) return (rel - 10) % 32;
    return 0;
  endfunction

  function automatic int exp_ack(int x, int npk, int isl);
    int rel;
    rel = x - isl;
    if (npk > 0 && rel >= 10 && rel < 10 + 32 * npk && (rel - 10) % 32 == 0) return 1;
    return 0;
  endfunction

  // policy: 0 low, 1 high, 2 one-cycle pulse at cx 643, 3 rise at cx 700
  task automatic run_line(input int y, input int policy, input int npk, input int last);
    for (int x = 0; x <= last; x++) begin
      chk_eq($sformatf("cx x%0d y%0d", x, y), int'(cx_d), x);
      chk_eq($sformatf("cy x%0d y%0d", x, y), int'(cy_d), y);
      chk_eq($sformatf("mode x%0d y%0d", x, y), int'(mode_d),
             exp_mode(x, y, npk, 800, 525, 640, 480, 644));
      chk_eq($sformatf("ack x%0d y%0d", x, y), int'(ack_d), exp_ack(x, npk, 644));
      chk_eq($sformatf("pcycle x%0d y%0d", x, y), int'(pc_d), exp_pc(x, npk, 644));
      chk_eq($sformatf("hsync x%0d y%0d", x, y), int'(hs_d), (x >= 656 && x <= 751) ? 1 : 0);
      chk_eq($sformatf("vsync x%0d y%0d", x, y), int'(vs_d), 0);
      case (policy)
        1:       pend_d = 1'b1;
        2:       pend_d = (x == 643);
        3:       pend_d = (x >= 700);
        default: pend_d = 1'b0;
      endcase
      @(negedge clk);
    end
  endtask

  initial begin
    rst_d  = 1'b1;
    rst_f  = 1'b1;
    pend_d = 1'b0;
    pend_f = 1'b0;
    repeat (2) @(negedge clk);

    chk_eq("rst cx", int'(cx_d), 0);
    chk_eq("rst cy", int'(cy_d), 0);
    chk_eq("rst mode", int'(mode_d), 3);
    chk_eq("rst ack", int'(ack_d), 0);
    chk_eq("rst pcycle", int'(pc_d), 0);
    chk_eq("rst hsync", int'(hs_d), 0);
    chk_eq("rst vsync", int'(vs_d), 0);

    rst_d = 1'b0;
    run_line(0, 0, 0, 799);
    run_line(1, 1, 2, 799);
    run_line(2, 1, 2, 799);
    run_line(3, 2, 1, 799);
    run_line(4, 3, 0, 799);
    run_line(5, 1, 2, 799);
    run_line(6, 1, 2, 659);

    chk_eq("pre-reset cx", int'(cx_d), 660);
    chk_eq("pre-reset mode", int'(mode_d), 6);
    chk_eq("pre-reset pcycle", int'(pc_d), 6);
    rst_d = 1'b1;
    @(negedge clk);
    chk_eq("mid-island rst cx", int'(cx_d), 0);
    chk_eq("mid-island rst cy", int'(cy_d), 0);
    chk_eq("mid-island rst mode", int'(mode_d), 3);
    chk_eq("mid-island rst ack", int'(ack_d), 0);
    chk_eq("mid-island rst pcycle", int'(pc_d), 0);
    rst_d = 1'b0;
    run_line(0, 0, 0, 799);

    rst_f = 1'b0;
    for (int y = 0; y < 525; y++) begin
      for (int x = 0; x < 78; x++) begin
        chk_eq($sformatf("frm pos x%0d y%0d", x, y), int'({cy_f, cx_f}), (y << 10) | x);
        chk_eq($sformatf("frm mode x%0d y%0d", x, y), int'(mode_f),
               exp_mode(x, y, 0, 78, 525, 16, 480, 20));
        chk_eq($sformatf("frm ack x%0d y%0d", x, y), int'(ack_f), 0);
        chk_eq($sformatf("frm hsync x%0d y%0d", x, y), int'(hs_f), 0);
        chk_eq($sformatf("frm vsync x%0d y%0d", x, y), int'(vs_f),
               (y >= 490 && y <= 491) ? 1 : 0);
        @(negedge clk);
      end
    end
    chk_eq("wrap cx", int'(cx_f), 0);
    chk_eq("wrap cy", int'(cy_f), 0);
    chk_eq("wrap mode", int'(mode_f), 3);

    pend_f = 1'b1;
    for (int x = 0; x < 78; x++) begin
      chk_eq($sformatf("max1 mode x%0d", x), int'(mode_f), exp_mode(x, 0, 1, 78, 525, 16, 480, 20));
      chk_eq($sformatf("max1 ack x%0d", x), int'(ack_f), exp_ack(x, 1, 20));
      chk_eq($sformatf("max1 pcycle x%0d", x), int'(pc_f), exp_pc(x, 1, 20));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
